// File: rtl/rasterbar_pkg.sv
// Shared types and base colour table for the rasterbar
// sequencer and its bounce sub-block.
package rasterbar_pkg;

    localparam int COLR_W = 12;

    typedef logic [COLR_W-1:0] colr_t;

    localparam colr_t BAR_COLRS [8] = '{
        12'h200, 12'h020, 12'h002, 12'h220,
        12'h202, 12'h022, 12'h222, 12'h210
    };

    typedef enum logic [2:0] {
        IDLE,
        ANIM,
        ARM,
        DRAW,
        DONE
    } state_t;

endpackage

// File: rtl/rasterbar_seq_if.sv
// Sequencer <-> renderer bundle: start pulse, colour, index
// and completion flags travelling between the two.
interface rasterbar_seq_if;
    import rasterbar_pkg::*;

    logic       bar_start;
    colr_t      bar_base_colr;
    logic [2:0] bar_idx;
    logic       seq_done;
    logic       bar_done;

    modport master (
        output bar_start,
        output bar_base_colr,
        output bar_idx,
        output seq_done,
        input  bar_done
    );

    modport slave (
        input  bar_start,
        input  bar_base_colr,
        input  bar_idx,
        input  seq_done,
        output bar_done
    );

endinterface

// File: rtl/bar_bounce.sv
// Bouncing vertical origin: moves by speed once per step,
// clamping at the limits and reversing direction there.
module bar_bounce
    import rasterbar_pkg::*;
#(
    parameter int LINE_W = 10,
    parameter int Y_MIN  = 16,
    parameter int Y_MAX  = 360
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              step,
    input  logic [3:0]        speed,
    output logic [LINE_W-1:0] origin
);

    localparam logic [LINE_W:0] LO = (LINE_W+1)'(Y_MIN);
    localparam logic [LINE_W:0] HI = (LINE_W+1)'(Y_MAX);

    logic              dir_up;
    logic              dir_d;
    logic [LINE_W-1:0] origin_d;
    logic [LINE_W:0]   ext;
    logic [LINE_W:0]   spd;
    logic [LINE_W:0]   sum;
    logic [LINE_W:0]   dif;

    assign ext = {1'b0, origin};
    assign spd = (LINE_W+1)'(speed);
    assign sum = ext + spd;
    assign dif = ext - spd;

    // next origin/direction; top bit of dif is its sign
    always_comb begin
        origin_d = origin;
        dir_d    = dir_up;
        if (step) begin
            if (!dir_up) begin
                if (sum > HI) begin
                    origin_d = HI[LINE_W-1:0];
                    dir_d    = 1'b1;
                end else begin
                    origin_d = sum[LINE_W-1:0];
                end
            end else begin
                if (dif[LINE_W] || dif < LO) begin
                    origin_d = LO[LINE_W-1:0];
                    dir_d    = 1'b0;
                end else begin
                    origin_d = dif[LINE_W-1:0];
                end
            end
        end
    end

    // origin and direction registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            origin <= LO[LINE_W-1:0];
            dir_up <= 1'b0;
        end else begin
            origin <= origin_d;
            dir_up <= dir_d;
        end
    end

endmodule

// File: rtl/rasterbar_seq.sv
// Per-frame bar sequencer: bounces the origin, then arms
// each bar at its line and waits for the renderer's done.
module rasterbar_seq
    import rasterbar_pkg::*;
#(
    parameter int BAR_CNT = 4,
    parameter int LINE_W  = 10,
    parameter int BAR_GAP = 24,
    parameter int Y_MIN   = 16,
    parameter int Y_MAX   = 360
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame,
    input  logic              line,
    input  logic [LINE_W-1:0] sy,
    input  logic [3:0]        speed,
    rasterbar_seq_if.master   rif
);

    localparam logic [2:0] LAST = 3'(BAR_CNT - 1);

    state_t            state_q;
    state_t            state_d;
    logic [2:0]        idx_q;
    logic [2:0]        idx_d;
    logic              start_q;
    logic              start_d;
    logic              guard_q;
    logic              done_q;
    logic              done_d;
    colr_t             colr_q;
    colr_t             colr_d;
    logic [LINE_W-1:0] origin;
    logic [LINE_W-1:0] target;
    logic              masked;

    bar_bounce #(
        .LINE_W (LINE_W),
        .Y_MIN  (Y_MIN),
        .Y_MAX  (Y_MAX)
    ) u_bounce (
        .clk    (clk),
        .rst_n  (rst_n),
        .step   (state_q == ANIM),
        .speed  (speed),
        .origin (origin)
    );

    assign target = origin + LINE_W'(int'(idx_q) * BAR_GAP);

    // renderer's done is stale for two cycles after a start
    assign masked = start_q | guard_q;

    // next state; frame overrides everything else
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        start_d = 1'b0;
        colr_d  = colr_q;
        done_d  = done_q;
        if (frame) begin
            state_d = ANIM;
            idx_d   = '0;
            done_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: state_d = IDLE;
                ANIM: state_d = ARM;
                ARM: begin
                    if (line && sy >= target) begin
                        start_d = 1'b1;
                        colr_d  = BAR_COLRS[idx_q];
                        state_d = DRAW;
                    end
                end
                DRAW: begin
                    if (rif.bar_done && !masked) begin
                        if (idx_q == LAST) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            idx_d   = idx_q + 3'd1;
                            state_d = ARM;
                        end
                    end
                end
                DONE: done_d = 1'b1;
                default: state_d = IDLE;
            endcase
        end
    end

    // sequencer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            start_q <= 1'b0;
            guard_q <= 1'b0;
            done_q  <= 1'b0;
            colr_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            start_q <= start_d;
            guard_q <= start_q;
            done_q  <= done_d;
            colr_q  <= colr_d;
        end
    end

    assign rif.bar_start     = start_q;
    assign rif.bar_base_colr = colr_q;
    assign rif.bar_idx       = idx_q;
    assign rif.seq_done      = done_q;

endmodule

// File: tb/tb_rasterbar_seq.sv
// Scoreboard bench for rasterbar_seq: frame-level model of
// bar start lines against a simple renderer stand-in.
module tb_rasterbar_seq;

    localparam int BAR_CNT = 4;
    localparam int LINE_W  = 10;
    localparam int GAP     = 24;
    localparam int YMIN    = 16;
    localparam int YMAX    = 360;
    localparam int LP      = 6;
    localparam int FULL    = 448;

    typedef struct {
        int         sy;
        logic [11:0] colr;
        int         idx;
        bit         stale;
        bit         last;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              frame = 1'b0;
    logic              line = 1'b0;
    logic [LINE_W-1:0] sy = '0;
    logic [3:0]        speed = '0;

    rasterbar_seq_if rif();

    rasterbar_seq #(
        .BAR_CNT (BAR_CNT),
        .LINE_W  (LINE_W),
        .BAR_GAP (GAP),
        .Y_MIN   (YMIN),
        .Y_MAX   (YMAX)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .frame (frame),
        .line  (line),
        .sy    (sy),
        .speed (speed),
        .rif   (rif)
    );

    always #5 clk = ~clk;

    logic [11:0] colrs [8] = '{
        12'h200, 12'h020, 12'h002, 12'h220,
        12'h202, 12'h022, 12'h222, 12'h210
    };

    exp_t sbq[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   line_cyc = -10;
    int   cur_sy = 0;

    int   m_origin = YMIN;
    bit   m_up = 1'b0;
    bit   exp_seq = 1'b0;
    int   bl [8];
    bit   bs [8];

    int   rend_cnt = 0;
    bit   pend = 1'b0;
    int   done_sy = 0;

    task automatic chk(string name, int act, int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0h need %0h", name, act, req);
        end
    endtask

    // monitor: pops an expected start on every bar_start
    initial begin : mon
        bit   prev;
        int   w;
        exp_t cur;
        prev = 1'b0;
        w = 0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (!rst_n) begin
                prev = 1'b0;
                w = 0;
            end else begin
                if (w > 0) begin
                    if (w < 3)
                        chk("stale_hold", int'(rif.bar_idx), cur.idx);
                    else if (cur.last)
                        chk("stale_last", int'(rif.seq_done), 1);
                    else
                        chk("stale_adv", int'(rif.bar_idx), cur.idx + 1);
                    w = (w == 3) ? 0 : w + 1;
                end
                if (rif.bar_start) begin
                    chk("start_width", int'(prev), 0);
                    if (sbq.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_start: got sy=%0d need none",
                                 cur_sy);
                    end else begin
                        cur = sbq.pop_front();
                        chk("start_sy", cur_sy, cur.sy);
                        chk("start_colr", int'(rif.bar_base_colr), int'(cur.colr));
                        chk("start_idx", int'(rif.bar_idx), cur.idx);
                        chk("start_lat", cyc, line_cyc + 1);
                        if (cur.stale) w = 1;
                    end
                end
                prev = rif.bar_start;
            end
        end
    end

    task automatic tick();
        int k;
        @(negedge clk);
        if (rst_n && rif.bar_start) begin
            k = rend_cnt;
            rend_cnt++;
            if (k < 8 && bs[k]) begin
                rif.bar_done = 1'b1;
                pend = 1'b0;
            end else if (k < 8) begin
                rif.bar_done = 1'b0;
                pend = 1'b1;
                done_sy = cur_sy + bl[k];
            end
        end
    endtask

    task automatic do_line(int s);
        tick();
        line = 1'b1;
        sy = LINE_W'(s);
        cur_sy = s;
        line_cyc = cyc;
        if (pend && s == done_sy) begin
            rif.bar_done = 1'b1;
            pend = 1'b0;
        end
        tick();
        line = 1'b0;
        repeat (LP - 2) tick();
    endtask

    task automatic set_bars(int l, bit s);
        for (int i = 0; i < 8; i++) begin
            bl[i] = l;
            bs[i] = s;
        end
    endtask

    task automatic model_frame(int nlines, int spd);
        int n;
        int tgt;
        int st;
        int dn;
        int prev_dn;
        if (!m_up) begin
            n = m_origin + spd;
            if (n > YMAX) begin
                m_origin = YMAX;
                m_up = 1'b1;
            end else m_origin = n;
        end else begin
            n = m_origin - spd;
            if (n < YMIN) begin
                m_origin = YMIN;
                m_up = 1'b0;
            end else m_origin = n;
        end
        exp_seq = 1'b0;
        prev_dn = -1000;
        for (int i = 0; i < BAR_CNT; i++) begin
            tgt = m_origin + i * GAP;
            st = (tgt > prev_dn + 1) ? tgt : prev_dn + 1;
            if (st > nlines - 1) break;
            sbq.push_back('{sy: st, colr: colrs[i], idx: i,
                            stale: bs[i], last: (i == BAR_CNT - 1)});
            dn = bs[i] ? st : st + bl[i];
            if (dn > nlines - 1) break;
            if (i == BAR_CNT - 1) exp_seq = 1'b1;
            prev_dn = dn;
        end
    endtask

    task automatic run_frame(int nlines, int spd);
        speed = 4'(spd);
        model_frame(nlines, spd);
        tick();
        frame = 1'b1;
        rend_cnt = 0;
        pend = 1'b0;
        tick();
        frame = 1'b0;
        tick();
        chk("frame_clr_done", int'(rif.seq_done), 0);
        chk("frame_clr_idx", int'(rif.bar_idx), 0);
        repeat (2) tick();
        for (int s = 0; s < nlines; s++) do_line(s);
        repeat (LP) tick();
    endtask

    task automatic end_check();
        chk("sb_empty", sbq.size(), 0);
        chk("seq_done", int'(rif.seq_done), int'(exp_seq));
        sbq.delete();
    endtask

    initial begin
        rif.bar_done = 1'b0;
        set_bars(10, 1'b0);
        repeat (3) @(negedge clk);
        chk("rst_start", int'(rif.bar_start), 0);
        chk("rst_colr", int'(rif.bar_base_colr), 0);
        chk("rst_idx", int'(rif.bar_idx), 0);
        chk("rst_seq", int'(rif.seq_done), 0);
        rst_n = 1'b1;
        for (int s = 0; s < 30; s++) do_line(s);
        chk("idle_idx", int'(rif.bar_idx), 0);

        run_frame(FULL, 0);
        end_check();

        set_bars(10, 1'b0);
        bl[0] = 44;
        bl[1] = 1;
        run_frame(FULL, 0);
        end_check();

        set_bars(10, 1'b1);
        run_frame(FULL, 0);
        end_check();

        set_bars(10, 1'b0);
        for (int j = 0; j < 22; j++) begin
            run_frame(0, 15);
            end_check();
        end
        run_frame(0, 4);
        end_check();
        run_frame(FULL, 15);
        end_check();
        run_frame(FULL, 15);
        end_check();

        run_frame(m_origin + 2 * GAP + 30, 0);
        end_check();
        run_frame(FULL, 5);
        end_check();

        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < 8; i++) begin
                bl[i] = $urandom_range(1, 40);
                bs[i] = ($urandom_range(0, 3) == 0);
            end
            run_frame(($urandom_range(0, 2) == 0) ?
                      $urandom_range(0, FULL - 1) : FULL,
                      $urandom_range(0, 15));
            end_check();
        end

        set_bars(10, 1'b0);
        run_frame(m_origin + GAP + 3, 0);
        chk("pre_rst_sb", sbq.size(), 0);
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_start", int'(rif.bar_start), 0);
        chk("arst_colr", int'(rif.bar_base_colr), 0);
        chk("arst_idx", int'(rif.bar_idx), 0);
        chk("arst_seq", int'(rif.seq_done), 0);
        sbq.delete();
        m_origin = YMIN;
        m_up = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        rif.bar_done = 1'b0;
        pend = 1'b0;
        for (int s = 0; s < 120; s++) do_line(s);
        chk("post_rst_idle", int'(rif.bar_idx), 0);
        run_frame(FULL, 0);
        end_check();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
